// File: rtl/fetch_unit.sv
// Fetch stage: in-order instruction fetch with epoch-tagged requests and sequence-numbered delivery to decode.
// Request is combinational from pc; responses pass to D in the same cycle; stale responses drain without D.

// Generic show-ahead FIFO; head_dat is valid whenever count is non-zero.
// Zero-cycle read of the head; the caller guarantees no push when full and no pop when empty.
module fetch_fifo #(
    parameter int p_width = 32,
    parameter int p_depth = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_vld,
    input  logic [p_width-1:0]         push_dat,
    input  logic                       pop_vld,
    output logic [p_width-1:0]         head_dat,
    output logic [$clog2(p_depth):0]   count
);
    localparam int aw = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int cw = $clog2(p_depth) + 1;

    logic [p_width-1:0] mem [p_depth];
    logic [aw-1:0]      wr_ptr;
    logic [aw-1:0]      rd_ptr;

    function automatic logic [aw-1:0] ptr_inc(input logic [aw-1:0] p);
        return (p == aw'(p_depth - 1)) ? '0 : p + aw'(1);
    endfunction

    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_vld) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_vld)  rd_ptr <= ptr_inc(rd_ptr);
            if (push_vld && !pop_vld) begin
                count <= count + cw'(1);
            end else if (pop_vld && !push_vld) begin
                count <= count - cw'(1);
            end
        end
    end
endmodule

module fetch_unit #(
    parameter logic [31:0] p_rst_addr      = 32'h0000_0200,
    parameter int          p_seq_num_bits  = 5,
    parameter int          p_num_in_flight = 4,
    parameter int          p_epoch_bits    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      mem_req_val,
    input  logic                      mem_req_rdy,
    output logic [31:0]               mem_req_addr,
    output logic [p_epoch_bits-1:0]   mem_req_opaque,
    input  logic                      mem_resp_val,
    output logic                      mem_resp_rdy,
    input  logic [31:0]               mem_resp_data,
    input  logic [p_epoch_bits-1:0]   mem_resp_opaque,
    output logic                      d_val,
    input  logic                      d_rdy,
    output logic [31:0]               d_inst,
    output logic [31:0]               d_pc,
    output logic [p_seq_num_bits-1:0] d_seq_num,
    input  logic                      squash_val,
    input  logic [31:0]               squash_target,
    input  logic [p_seq_num_bits-1:0] squash_seq_num,
    input  logic                      commit_val,
    input  logic [p_seq_num_bits-1:0] commit_seq_num
);
    localparam int sw = p_seq_num_bits;
    localparam int ew = p_epoch_bits;
    localparam int cw = $clog2(p_num_in_flight) + 1;
    localparam logic [cw-1:0] max_in_flight = cw'(p_num_in_flight);
    localparam logic [sw-1:0] max_live      = '1;

    logic [31:0]   pc;
    logic [ew-1:0] epoch;
    logic [sw-1:0] seq_tail;
    logic [sw-1:0] seq_head;
    logic [sw-1:0] live_cnt;
    logic [sw-1:0] head_next;
    logic [cw-1:0] in_flight;
    logic [31:0]   fifo_pc;
    logic          current;
    logic          req_fire;
    logic          resp_fire;
    logic          d_fire;

    always_comb begin
        current        = (mem_resp_opaque == epoch);
        mem_req_val    = !rst && !squash_val && (in_flight < max_in_flight);
        mem_req_addr   = pc;
        mem_req_opaque = epoch;
        d_val          = !rst && mem_resp_val && current && !squash_val && (live_cnt < max_live);
        d_inst         = mem_resp_data;
        d_pc           = fifo_pc;
        d_seq_num      = seq_tail;
        d_fire         = d_val && d_rdy;
        // Stale responses are accepted unconditionally so old-epoch traffic never blocks fetch.
        mem_resp_rdy   = !rst && !squash_val && (!current || d_fire);
        req_fire       = mem_req_val && mem_req_rdy;
        resp_fire      = mem_resp_val && mem_resp_rdy;
        head_next      = commit_val ? seq_head + sw'(1) : seq_head;
    end

    fetch_fifo #(
        .p_width (32),
        .p_depth (p_num_in_flight)
    ) u_pc_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (req_fire),
        .push_dat (pc),
        .pop_vld  (resp_fire),
        .head_dat (fifo_pc),
        .count    (in_flight)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= p_rst_addr;
            epoch    <= '0;
            seq_tail <= '0;
            seq_head <= '0;
            live_cnt <= '0;
        end else begin
            seq_head <= head_next;
            if (squash_val) begin
                // Live window is rebuilt from the post-commit head so same-cycle commits are honoured.
                pc       <= squash_target;
                epoch    <= epoch + ew'(1);
                seq_tail <= squash_seq_num + sw'(1);
                live_cnt <= squash_seq_num + sw'(1) - head_next;
            end else begin
                if (req_fire) pc <= pc + 32'd4;
                if (d_fire) seq_tail <= seq_tail + sw'(1);
                if (d_fire && !commit_val) begin
                    live_cnt <= live_cnt + sw'(1);
                end else if (commit_val && !d_fire) begin
                    live_cnt <= live_cnt - sw'(1);
                end
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && commit_val) begin
            assert (commit_seq_num == seq_head)
                else $error("commit out of order: seq %0d, head %0d", commit_seq_num, seq_head);
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized and directed bench for fetch_unit against a queue-based reference model and an in-order memory.
module tb_fetch_unit;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        mem_req_val, mem_req_rdy = 1'b0;
    logic [31:0] mem_req_addr;
    logic [7:0]  mem_req_opaque;
    logic        mem_resp_val = 1'b0, mem_resp_rdy;
    logic [31:0] mem_resp_data = '0;
    logic [7:0]  mem_resp_opaque = '0;
    logic        d_val, d_rdy = 1'b0;
    logic [31:0] d_inst, d_pc;
    logic [4:0]  d_seq_num;
    logic        squash_val = 1'b0;
    logic [31:0] squash_target = '0;
    logic [4:0]  squash_seq_num = '0;
    logic        commit_val = 1'b0;
    logic [4:0]  commit_seq_num = '0;

    fetch_unit dut (
        .clk(clk), .rst(rst),
        .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy),
        .mem_req_addr(mem_req_addr), .mem_req_opaque(mem_req_opaque),
        .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy),
        .mem_resp_data(mem_resp_data), .mem_resp_opaque(mem_resp_opaque),
        .d_val(d_val), .d_rdy(d_rdy), .d_inst(d_inst), .d_pc(d_pc), .d_seq_num(d_seq_num),
        .squash_val(squash_val), .squash_target(squash_target), .squash_seq_num(squash_seq_num),
        .commit_val(commit_val), .commit_seq_num(commit_seq_num)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  ep;
    } req_t;

    // Outstanding requests double as the in-order memory and the expected pc order.
    req_t        out_q[$];
    int          live_q[$];
    logic [31:0] m_pc;
    int          m_epoch, m_tail, m_head;

    logic [31:0] log_req_addr[$];
    logic [7:0]  log_req_ep[$];
    logic [31:0] log_d_pc[$];
    int          log_d_seq[$];

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        out_q.delete();
        live_q.delete();
        m_pc    = 32'h200;
        m_epoch = 0;
        m_tail  = 0;
        m_head  = 0;
    endtask

    task automatic step(input bit r, input bit sq, input logic [31:0] st, input int ss,
                        input bit cm_in, input bit drdy, input bit mrdy, input bit ren);
        bit   cm, e_req, e_stale, e_dval, e_rrdy, req_f, resp_f, d_f;
        int   keep;
        req_t e;
        cm = cm_in && !r && live_q.size() > 0;
        sq = sq && !r;
        @(posedge clk);
        #1;
        rst            = r;
        squash_val     = sq;
        squash_target  = st;
        squash_seq_num = 5'(ss);
        commit_val     = cm;
        commit_seq_num = 5'(m_head);
        d_rdy          = drdy && !r;
        mem_req_rdy    = mrdy && !r;
        mem_resp_val   = !r && ren && out_q.size() > 0;
        if (out_q.size() > 0) begin
            mem_resp_data   = ~out_q[0].addr;
            mem_resp_opaque = out_q[0].ep;
        end else begin
            mem_resp_data   = $urandom;
            mem_resp_opaque = 8'($urandom);
        end
        @(negedge clk);
        if (mem_req_val && mem_req_rdy) begin
            log_req_addr.push_back(mem_req_addr);
            log_req_ep.push_back(mem_req_opaque);
        end
        if (d_val && d_rdy) begin
            log_d_pc.push_back(d_pc);
            log_d_seq.push_back(int'(d_seq_num));
        end
        if (r) begin
            check("rst_mem_req_val", 32'(mem_req_val), 32'd0);
            check("rst_mem_resp_rdy", 32'(mem_resp_rdy), 32'd0);
            check("rst_d_val", 32'(d_val), 32'd0);
            model_reset();
            return;
        end
        e_req   = !sq && out_q.size() < 4;
        e_stale = (mem_resp_opaque != 8'(m_epoch));
        e_dval  = mem_resp_val && !e_stale && !sq && live_q.size() < 31;
        e_rrdy  = !sq && (e_stale || (drdy && e_dval));
        check("mem_req_val", 32'(mem_req_val), 32'(e_req));
        if (e_req) begin
            check("mem_req_addr", mem_req_addr, m_pc);
            check("mem_req_opaque", 32'(mem_req_opaque), 32'(m_epoch));
        end
        check("mem_resp_rdy", 32'(mem_resp_rdy), 32'(e_rrdy));
        check("d_val", 32'(d_val), 32'(e_dval));
        if (e_dval) begin
            check("d_pc", d_pc, out_q[0].addr);
            check("d_inst", d_inst, ~out_q[0].addr);
            check("d_seq_num", 32'(d_seq_num), 32'(m_tail));
        end
        req_f  = e_req && mrdy;
        resp_f = mem_resp_val && e_rrdy;
        d_f    = e_dval && drdy;
        if (resp_f) out_q.delete(0);
        if (req_f) begin
            e.addr = m_pc;
            e.ep   = 8'(m_epoch);
            out_q.push_back(e);
            m_pc = m_pc + 32'd4;
        end
        if (d_f) begin
            live_q.push_back(m_tail);
            m_tail = (m_tail + 1) % 32;
        end
        if (cm) begin
            live_q.delete(0);
            m_head = (m_head + 1) % 32;
        end
        if (sq) begin
            m_pc    = st;
            m_epoch = (m_epoch + 1) % 256;
            m_tail  = (ss + 1) % 32;
            keep    = (ss + 1 - m_head + 64) % 32;
            while (live_q.size() > keep) live_q.delete(live_q.size() - 1);
        end
    endtask

    task automatic run(input int n, input bit drdy, input bit mrdy, input bit ren);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 0, 1'b0, drdy, mrdy, ren);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 32'h0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    int          rb, db, base, hd, k, rss;
    bit          rcm, rsq;
    logic [31:0] rtgt;

    initial begin
        model_reset();
        do_reset();
        do_reset();

        // Straight-line fetch with a 1-cycle memory.
        rb = log_req_addr.size();
        db = log_d_pc.size();
        run(6, 1'b1, 1'b1, 1'b1);
        check("r032_req0", log_req_addr[rb], 32'h200);
        check("r032_req1", log_req_addr[rb+1], 32'h204);
        check("r032_req2", log_req_addr[rb+2], 32'h208);
        check("r032_d0_pc", log_d_pc[db], 32'h200);
        check("r032_d0_seq", 32'(log_d_seq[db]), 32'd0);
        check("r032_d1_pc", log_d_pc[db+1], 32'h204);
        check("r032_d2_pc", log_d_pc[db+2], 32'h208);
        check("r032_d2_seq", 32'(log_d_seq[db+2]), 32'd2);

        // Silent memory: the in-flight limit stops fetch after four requests.
        do_reset();
        rb = log_req_addr.size();
        run(8, 1'b1, 1'b1, 1'b0);
        check("r033_nreq", 32'(log_req_addr.size() - rb), 32'd4);
        check("r033_req3", log_req_addr[rb+3], 32'h20C);
        check("r033_req_val_low", 32'(mem_req_val), 32'd0);

        // Squash with three requests in flight.
        do_reset();
        rb = log_req_addr.size();
        db = log_d_pc.size();
        run(2, 1'b1, 1'b1, 1'b0);
        run(3, 1'b1, 1'b0, 1'b1);
        run(3, 1'b1, 1'b1, 1'b0);
        check("r034_outstanding", 32'(out_q.size()), 32'd3);
        step(1'b0, 1'b1, 32'h400, 1, 1'b0, 1'b1, 1'b1, 1'b1);
        run(8, 1'b1, 1'b1, 1'b1);
        check("r034_req_addr", log_req_addr[rb+5], 32'h400);
        check("r034_req_epoch", 32'(log_req_ep[rb+5]), 32'd1);
        check("r034_d_pc", log_d_pc[db+2], 32'h400);
        check("r034_d_seq", 32'(log_d_seq[db+2]), 32'd2);

        // Live-window limit of 31 outstanding sequence numbers.
        do_reset();
        db = log_d_pc.size();
        run(45, 1'b1, 1'b1, 1'b1);
        check("r035_ndeliv", 32'(log_d_pc.size() - db), 32'd31);
        check("r035_last_seq", 32'(log_d_seq[db+30]), 32'd30);
        check("r035_d_val_low", 32'(d_val), 32'd0);
        step(1'b0, 1'b0, 32'h0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
        run(5, 1'b1, 1'b1, 1'b1);
        check("r035_ndeliv_after", 32'(log_d_pc.size() - db), 32'd32);
        check("r035_seq31", 32'(log_d_seq[db+31]), 32'd31);

        // Squash, commit and a current response in the same cycle.
        do_reset();
        db = log_d_pc.size();
        run(4, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 32'h800, 1, 1'b1, 1'b1, 1'b1, 1'b1);
        check("r036_no_deliv", 32'(log_d_pc.size() - db), 32'd3);
        check("r036_live", 32'(live_q.size()), 32'd1);
        run(8, 1'b1, 1'b1, 1'b1);
        check("r036_d_pc", log_d_pc[db+3], 32'h800);
        check("r036_d_seq", 32'(log_d_seq[db+3]), 32'd2);

        // Reset with requests outstanding and a populated live window.
        do_reset();
        run(6, 1'b1, 1'b1, 1'b1);
        run(1, 1'b1, 1'b1, 1'b0);
        check("r037_outstanding", 32'(out_q.size()), 32'd2);
        check("r037_live", 32'(live_q.size()), 32'd5);
        do_reset();
        rb = log_req_addr.size();
        db = log_d_pc.size();
        run(3, 1'b1, 1'b1, 1'b1);
        check("r037_req_addr", log_req_addr[rb], 32'h200);
        check("r037_d_pc", log_d_pc[db], 32'h200);
        check("r037_d_seq", 32'(log_d_seq[db]), 32'd0);

        // Randomized traffic with squashes and commits.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rcm  = live_q.size() > 0 && $urandom_range(0, 99) < 30;
            rsq  = $urandom_range(0, 99) < 4;
            base = live_q.size() - (rcm ? 1 : 0);
            hd   = (m_head + (rcm ? 1 : 0)) % 32;
            k    = $urandom_range(0, base);
            rss  = (hd + k + 31) % 32;
            rtgt = 32'h1000 | {22'd0, 8'($urandom), 2'b00};
            step(1'b0, rsq, rtgt, rss, rcm,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter p_rst_addr, default 32'h00000200: PC loaded at reset.
REQ-002 Parameter p_seq_num_bits, default 5: width of sequence numbers handed to D.
REQ-003 Parameter p_num_in_flight, default 4: maximum outstanding memory requests (power of 2).
REQ-004 Parameter p_epoch_bits, default 8: epoch tag width carried in the memory opaque field.
REQ-005 clk  input  1  clock; all state updates on posedge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 mem_req_val  output  1  / mem_req_rdy  input  1  request handshake; transfer when both high.
REQ-008 mem_req_addr  output  32  fetch address; mem_req_opaque  output  p_epoch_bits  epoch tag.
REQ-009 mem_resp_val  input  1  / mem_resp_rdy  output  1  response handshake; responses return in request order.
REQ-010 mem_resp_data  input  32  instruction word; mem_resp_opaque  input  p_epoch_bits  echoed epoch.
REQ-011 d_val  output  1  / d_rdy  input  1  F->D handshake; transfer when both high.
REQ-012 d_inst  output  32, d_pc  output  32, d_seq_num  output  p_seq_num_bits  instruction payload.
REQ-013 squash_val  input  1, squash_target  input  32, squash_seq_num  input  p_seq_num_bits  redirect.
REQ-014 commit_val  input  1, commit_seq_num  input  p_seq_num_bits  in-order commit of oldest live seq number.

Function
REQ-015 State: pc, epoch, pc FIFO (depth p_num_in_flight, entry = pc), in-flight count, seq tail (next to allocate), seq head (oldest uncommitted), live count.
REQ-016 mem_req_val = !squash_val & in-flight count < p_num_in_flight; mem_req_addr = pc; mem_req_opaque = epoch.
REQ-017 On request transfer: push pc into FIFO, pc <= pc + 4, in-flight count +1.
REQ-018 Response is current iff mem_resp_opaque == epoch; otherwise stale.
REQ-019 d_val = mem_resp_val & current & !squash_val & live count < 2^p_seq_num_bits - 1.
REQ-020 d_inst = mem_resp_data, d_pc = FIFO head, d_seq_num = seq tail; payload don't-care when d_val low.
REQ-021 mem_resp_rdy = !squash_val & (stale | (d_rdy & d_val)); stale responses consumed and discarded, never presented to D.
REQ-022 On response transfer: pop FIFO, in-flight count -1; if current and delivered, seq tail +1 (wraps mod 2^p_seq_num_bits), live count +1.
REQ-023 Request and response transfer in same cycle: in-flight count unchanged; FIFO push and pop both occur.
REQ-024 squash_val cycle: no request, no response consumed, d_val = 0; next state pc <= squash_target, epoch <= epoch + 1 (wraps), seq tail <= squash_seq_num + 1, live count <= (squash_seq_num + 1 - seq head) mod 2^p_seq_num_bits.
REQ-025 Outstanding requests are not cancelled on squash; they drain as stale via REQ-021.
REQ-026 commit_val: seq head +1, live count -1; commit_seq_num SHALL equal seq head (assertion under non-synthesis builds).
REQ-027 Commit and delivery in same cycle: live count unchanged; commit and squash in same cycle: head advances first, REQ-024 live count computed from the advanced head.
REQ-028 Full conditions: in-flight == p_num_in_flight blocks requests only; live count == 2^p_seq_num_bits - 1 blocks delivery only (response held, mem_resp_rdy low).

Reset
REQ-029 On rst: pc = p_rst_addr, epoch = 0, FIFO empty, in-flight = 0, seq tail = seq head = 0, live = 0.
REQ-030 During rst all outputs val/rdy low; first request (addr p_rst_addr) may assert the cycle after rst deasserts.
REQ-031 Memory shares rst; no response for a pre-reset request SHALL arrive after reset.

Verification
REQ-032 Reset, mem always ready, d_rdy=1, 1-cycle memory -> requests 0x200,0x204,0x208; D receives pc 0x200/seq 0, 0x204/seq 1, 0x208/seq 2 in order.
REQ-033 Memory never responds -> exactly 4 requests (0x200..0x20C) then mem_req_val stays low.
REQ-034 3 requests outstanding, squash target 0x400 seq 1 -> next request 0x400 with epoch 1; 3 old responses dropped; next D transfer pc 0x400, seq 2.
REQ-035 No commits, d_rdy=1 -> exactly 31 deliveries (seq 0..30), then d_val low; one commit (seq 0) -> one further delivery, seq 31.
REQ-036 squash, commit and valid current response in one cycle -> no D transfer, head +1, post-squash state per REQ-024/027.
REQ-037 rst asserted with 2 requests outstanding and live count 5 -> all state per REQ-029 next cycle; fetch restarts at 0x200 seq 0.
